audio_fx_chain: RTL and testbench

- Parametrised multi-channel audio effect stage, the successor to the single-effect stage between the SPI receiver and the DAC driver.
- Takes time-interleaved signed PCM samples with a valid strobe and a channel tag.
- Applies a per-sample selectable mode: bypass, gain, feed-forward echo, or echo followed by gain. Output is saturating.
- Emits tagged samples to the DAC driver after a fixed 2-cycle latency and keeps a clip counter.

---
 rtl/audio_fx_chain_if.sv | 28 ++
 rtl/audio_fx_chain.sv | 155 +++++++++++++++
 tb/tb_audio_fx_chain.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_fx_chain_if.sv
// Sample stream bundle between the effect stage and its neighbours.
// Carries the tagged input sample with its per-sample controls, and the tagged output sample.
interface audio_fx_chain_if #(
    parameter int W   = 16,
    parameter int NCH = 2
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           in_valid;
    logic [CHW-1:0] in_ch;
    logic [W-1:0]   audio_in;
    logic [1:0]     mode;
    logic [1:0]     gain_shift;
    logic [2:0]     decay_shift;
    logic           out_valid;
    logic [CHW-1:0] out_ch;
    logic [W-1:0]   audio_out;

    modport master (
        output in_valid, in_ch, audio_in, mode, gain_shift, decay_shift,
        input  out_valid, out_ch, audio_out
    );

    modport slave (
        input  in_valid, in_ch, audio_in, mode, gain_shift, decay_shift,
        output out_valid, out_ch, audio_out
    );
endinterface

// File: rtl/audio_fx_chain.sv
// Multi-channel audio effect stage: bypass, gain, feed-forward echo or echo+gain,
// saturating output with a clip counter, fixed 2-cycle latency.
module audio_fx_chain #(
    parameter int W     = 16,
    parameter int NCH   = 2,
    parameter int DEPTH = 4096,
    parameter int CLIPW = 16
) (
    input  logic             clk_25mhz,
    input  logic             reset,
    audio_fx_chain_if.slave  bus,
    output logic [CLIPW-1:0] clip_cnt,
    input  logic             clip_clr
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int AW  = CHW + PW;
    localparam int WE  = W + 5;
    localparam logic signed [WE-1:0] Y_MAX = {6'h00, {(W-1){1'b1}}};
    localparam logic signed [WE-1:0] Y_MIN = {6'h3f, {(W-1){1'b0}}};

    logic [PW-1:0]         ptr_q [NCH];
    logic [PW-1:0]         ptr_d [NCH];
    logic [NCH-1:0]        filled_q, filled_d;

    logic                  s1_valid_q, s1_valid_d;
    logic [CHW-1:0]        s1_ch_q, s1_ch_d;
    logic signed [W-1:0]   s1_x_q, s1_x_d;
    logic [1:0]            s1_mode_q, s1_mode_d;
    logic [1:0]            s1_gain_q, s1_gain_d;
    logic [2:0]            s1_decay_q, s1_decay_d;
    logic                  s1_filled_q, s1_filled_d;
    logic [PW-1:0]         s1_ptr_q, s1_ptr_d;

    logic                  out_valid_q, out_valid_d;
    logic [CHW-1:0]        out_ch_q, out_ch_d;
    logic signed [W-1:0]   audio_out_q, audio_out_d;
    logic [CLIPW-1:0]      clip_cnt_q, clip_cnt_d;

    logic signed [W-1:0]   mem [NCH*DEPTH];
    logic signed [W-1:0]   ram_rd_q;

    logic                  accept;
    logic [CHW-1:0]        ch_idx;
    logic [AW-1:0]         rd_addr, wr_addr;
    logic signed [WE-1:0]  x_ext, d_ext, echo_term, sum_y, y_full;
    logic signed [W-1:0]   d_eff, y_sat;
    logic                  clip_hi, clip_lo, clip_hit;

    // Out-of-range channel tags are dropped; ch_idx stays in range for all indexing.
    assign accept  = bus.in_valid && (32'(bus.in_ch) < NCH);
    assign ch_idx  = accept ? bus.in_ch : '0;
    assign rd_addr = {ch_idx, ptr_q[ch_idx]};
    assign wr_addr = {s1_ch_q, s1_ptr_q};

    always_comb begin
        ptr_d       = ptr_q;
        filled_d    = filled_q;
        s1_valid_d  = accept;
        s1_ch_d     = ch_idx;
        s1_x_d      = $signed(bus.audio_in);
        s1_mode_d   = bus.mode;
        s1_gain_d   = bus.gain_shift;
        s1_decay_d  = bus.decay_shift;
        s1_filled_d = filled_q[ch_idx];
        s1_ptr_d    = ptr_q[ch_idx];
        if (accept) begin
            ptr_d[ch_idx] = ptr_q[ch_idx] + PW'(1);
            if (ptr_q[ch_idx] == PW'(DEPTH - 1)) begin
                filled_d[ch_idx] = 1'b1;
            end
        end
    end

    // The filled flag was captured before the wrap update, so the first pass reads as silence.
    always_comb begin
        d_eff     = s1_filled_q ? ram_rd_q : '0;
        x_ext     = WE'(s1_x_q);
        d_ext     = WE'(d_eff);
        echo_term = d_ext >>> s1_decay_q;
        sum_y     = s1_mode_q[1] ? (x_ext + echo_term) : x_ext;
        y_full    = s1_mode_q[0] ? (sum_y <<< s1_gain_q) : sum_y;
        clip_hi   = y_full > Y_MAX;
        clip_lo   = y_full < Y_MIN;
        if (clip_hi) begin
            y_sat = {1'b0, {(W-1){1'b1}}};
        end else if (clip_lo) begin
            y_sat = {1'b1, {(W-1){1'b0}}};
        end else begin
            y_sat = y_full[W-1:0];
        end
        clip_hit    = s1_valid_q && (clip_hi || clip_lo);
        out_valid_d = s1_valid_q;
        out_ch_d    = s1_valid_q ? s1_ch_q : out_ch_q;
        audio_out_d = s1_valid_q ? y_sat : audio_out_q;
        if (clip_clr) begin
            clip_cnt_d = '0;
        end else if (clip_hit && (clip_cnt_q != '1)) begin
            clip_cnt_d = clip_cnt_q + CLIPW'(1);
        end else begin
            clip_cnt_d = clip_cnt_q;
        end
    end

    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                ptr_q[i] <= '0;
            end
            filled_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_x_q      <= '0;
            s1_mode_q   <= '0;
            s1_gain_q   <= '0;
            s1_decay_q  <= '0;
            s1_filled_q <= 1'b0;
            s1_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            audio_out_q <= '0;
            clip_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            filled_q    <= filled_d;
            s1_valid_q  <= s1_valid_d;
            s1_ch_q     <= s1_ch_d;
            s1_x_q      <= s1_x_d;
            s1_mode_q   <= s1_mode_d;
            s1_gain_q   <= s1_gain_d;
            s1_decay_q  <= s1_decay_d;
            s1_filled_q <= s1_filled_d;
            s1_ptr_q    <= s1_ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            audio_out_q <= audio_out_d;
            clip_cnt_q  <= clip_cnt_d;
        end
    end

    // Delay RAM keeps no reset so it maps onto block memory; history is written in every mode.
    always_ff @(posedge clk_25mhz) begin
        if (accept) begin
            ram_rd_q <= mem[rd_addr];
        end
        if (s1_valid_q) begin
            mem[wr_addr] <= s1_x_q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.audio_out = audio_out_q;
    assign clip_cnt      = clip_cnt_q;
endmodule

// File: tb/tb_audio_fx_chain.sv
// Self-checking bench for audio_fx_chain: spec-derived vector table, hand-written
// reset/drop sequences, and randomized traffic against a per-channel history model.
`timescale 1ns/1ps
module tb_audio_fx_chain;
    localparam int DEPTH = 4;

    typedef struct {
        bit          rst;
        bit          valid;
        bit          ch;
        logic [15:0] x;
        logic [1:0]  mode;
        logic [1:0]  gain;
        logic [2:0]  decay;
        bit          clr;
        logic [15:0] y;
        bit          clip;
        int          gap;
    } vec_t;

    typedef struct {
        bit          ch;
        logic [15:0] y;
        bit          clip;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clip_clr = 1'b0;
    logic        clip_clr3 = 1'b0;
    logic [15:0] clip_cnt, clip_cnt3;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     clip_model = 0;
    exp_t        sb [$];
    logic [15:0] hist [2][$];
    vec_t        tbl [$];

    audio_fx_chain_if #(.W(16), .NCH(2)) bus ();
    audio_fx_chain_if #(.W(16), .NCH(3)) bus3 ();

    audio_fx_chain #(.W(16), .NCH(2), .DEPTH(DEPTH), .CLIPW(16)) dut (
        .clk_25mhz (clk),
        .reset     (reset),
        .bus       (bus),
        .clip_cnt  (clip_cnt),
        .clip_clr  (clip_clr)
    );

    audio_fx_chain #(.W(16), .NCH(3), .DEPTH(DEPTH), .CLIPW(16)) dut3 (
        .clk_25mhz (clk),
        .reset     (reset),
        .bus       (bus3),
        .clip_cnt  (clip_cnt3),
        .clip_clr  (clip_clr3)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: echo is simply the same-channel sample DEPTH accepts ago, silence before that.
    function automatic void model(input bit ch, input logic [15:0] x, input logic [1:0] mode,
                                  input logic [1:0] gain, input logic [2:0] decay,
                                  output logic [15:0] y, output bit clip);
        longint xv, dv, v;
        int n;
        n  = hist[ch].size();
        xv = longint'($signed(x));
        dv = (n >= DEPTH) ? longint'($signed(hist[ch][n-DEPTH])) : 0;
        v  = xv;
        if (mode[1]) v = v + (dv >>> decay);
        if (mode[0]) v = v * (longint'(1) << gain);
        clip = (v > 32767) || (v < -32768);
        if (v > 32767)       y = 16'h7fff;
        else if (v < -32768) y = 16'h8000;
        else                 y = v[15:0];
    endfunction

    function automatic vec_t row(input bit rst, input bit ch, input logic [15:0] x,
                                 input logic [1:0] mode, input logic [1:0] gain,
                                 input logic [2:0] decay, input logic [15:0] y,
                                 input bit clip, input int gap);
        vec_t v;
        v.rst = rst; v.valid = 1'b1; v.ch = ch; v.x = x; v.mode = mode; v.gain = gain;
        v.decay = decay; v.clr = 1'b0; v.y = y; v.clip = clip; v.gap = gap;
        return v;
    endfunction

    function automatic vec_t clr_row();
        vec_t v;
        v = row(1'b0, 1'b0, 16'h0, 2'd0, 2'd0, 3'd0, 16'h0, 1'b0, 0);
        v.valid = 1'b0;
        v.clr   = 1'b1;
        return v;
    endfunction

    task automatic clear_model();
        sb.delete();
        hist[0].delete();
        hist[1].delete();
        clip_model = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            clip_clr = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit use_model);
        logic [15:0] my;
        bit mc;
        exp_t e;
        @(negedge clk);
        bus.in_valid    = v.valid;
        bus.in_ch       = v.ch;
        bus.audio_in    = v.x;
        bus.mode        = v.mode;
        bus.gain_shift  = v.gain;
        bus.decay_shift = v.decay;
        clip_clr        = v.clr;
        if (v.valid) begin
            model(v.ch, v.x, v.mode, v.gain, v.decay, my, mc);
            e.ch   = v.ch;
            e.y    = use_model ? my : v.y;
            e.clip = use_model ? mc : v.clip;
            e.due  = cyc + 2;
            sb.push_back(e);
            hist[v.ch].push_back(v.x);
        end
        repeat (v.gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            clip_clr = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus3.in_valid = 1'b0;
        clip_clr = 1'b0;
        clear_model();
        repeat (2) begin
            @(posedge clk);
            #2;
            checkOutput("rst_out_valid", bus.out_valid, 0);
            checkOutput("rst_out_ch", bus.out_ch, 0);
            checkOutput("rst_audio_out", bus.audio_out, 0);
            checkOutput("rst_clip_cnt", clip_cnt, 0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Scoreboard: every output must match the oldest pending expectation exactly on its due cycle.
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #2;
        if (reset) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_output got no out_valid expected %h due cycle %0d", sb[0].y, sb[0].due);
                void'(sb.pop_front());
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_output got %h ch %0d expected no out_valid (cycle %0d)",
                             bus.audio_out, bus.out_ch, cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("latency", cyc, e.due);
                    checkOutput("out_ch", bus.out_ch, e.ch);
                    checkOutput("audio_out", bus.audio_out, e.y);
                    if (e.clip && clip_model < 65535) clip_model++;
                end
            end
            if (clip_clr) clip_model = 0;
            checkOutput("clip_cnt", clip_cnt, clip_model);
        end
    end

    initial begin : watchdog
        #5ms;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : main
        vec_t v;
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.audio_in = '0;
        bus.mode = '0; bus.gain_shift = '0; bus.decay_shift = '0;
        bus3.in_valid = 1'b0; bus3.in_ch = '0; bus3.audio_in = '0;
        bus3.mode = '0; bus3.gain_shift = '0; bus3.decay_shift = '0;

        // Bypass and gain clipping with clear
        tbl.push_back(row(1, 0, 16'h1234, 2'd0, 2'd0, 3'd0, 16'h1234, 0, 0));
        tbl.push_back(row(0, 0, 16'h8001, 2'd0, 2'd0, 3'd0, 16'h8001, 0, 0));
        tbl.push_back(row(1, 0, 16'h7000, 2'd1, 2'd1, 3'd0, 16'h7fff, 1, 0));
        tbl.push_back(row(0, 0, 16'h9000, 2'd1, 2'd1, 3'd0, 16'h8000, 1, 0));
        tbl.push_back(row(0, 0, 16'h0100, 2'd1, 2'd1, 3'd0, 16'h0200, 0, 0));
        tbl.push_back(clr_row());
        // Preload RAM with full-scale data, then echo fill after reset must not see it
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                tbl.push_back(row(k == 0 && c == 0, c[0], 16'h7fff, 2'd0, 2'd0, 3'd0, 16'h7fff, 0, 0));
            end
        end
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(row(k == 0, 0, (k == 0) ? 16'h4000 : 16'h0, 2'd2, 2'd0, 3'd1,
                              (k == 0) ? 16'h4000 : ((k == 4) ? 16'h2000 : 16'h0), 0, 0));
        end
        // Interleaved channels, back to back and with idle gaps
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [15:0] val;
                    val = (c == 0) ? 16'h1000 : 16'h0100;
                    tbl.push_back(row(k == 0 && c == 0, c[0], (k == 0) ? val : 16'h0, 2'd2, 2'd0, 3'd0,
                                      (k == 0 || k == 4) ? val : 16'h0, 0, r * 3));
                end
            end
        end
        // Echo+gain clipping, then a mode switch to bypass on the very next sample
        tbl.push_back(row(1, 0, 16'h3000, 2'd3, 2'd2, 3'd0, 16'h7fff, 1, 0));
        tbl.push_back(row(0, 0, 16'h0000, 2'd3, 2'd2, 3'd0, 16'h0000, 0, 0));
        tbl.push_back(row(0, 0, 16'h0000, 2'd3, 2'd2, 3'd0, 16'h0000, 0, 0));
        tbl.push_back(row(0, 0, 16'h0000, 2'd3, 2'd2, 3'd0, 16'h0000, 0, 0));
        tbl.push_back(row(0, 0, 16'h3000, 2'd3, 2'd2, 3'd0, 16'h7fff, 1, 0));
        tbl.push_back(row(0, 0, 16'h3000, 2'd0, 2'd2, 3'd0, 16'h3000, 0, 0));

        $display("[TB] applying %0d table vectors", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                idle(3);
                do_reset();
            end
            applyStimulus(tbl[i], 1'b0);
        end
        idle(3);

        // Reset with two samples in flight: neither may emerge, buffers restart unfilled
        do_reset();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_ch = 1'b0; bus.audio_in = 16'h1111;
        bus.mode = 2'd0; bus.gain_shift = 2'd0; bus.decay_shift = 3'd0;
        @(negedge clk);
        bus.audio_in = 16'h2222;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        clear_model();
        repeat (3) begin
            @(posedge clk);
            #2;
            checkOutput("midrst_out_valid", bus.out_valid, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        applyStimulus(row(0, 0, 16'h0011, 2'd2, 2'd0, 3'd0, 16'h0011, 0, 0), 1'b0);
        applyStimulus(row(0, 0, 16'h0022, 2'd2, 2'd0, 3'd0, 16'h0022, 0, 0), 1'b0);
        applyStimulus(row(0, 0, 16'h0033, 2'd2, 2'd0, 3'd0, 16'h0033, 0, 0), 1'b0);
        applyStimulus(row(0, 0, 16'h0044, 2'd2, 2'd0, 3'd0, 16'h0044, 0, 0), 1'b0);
        applyStimulus(row(0, 0, 16'h0000, 2'd2, 2'd0, 3'd0, 16'h0011, 0, 0), 1'b0);
        idle(3);

        // Channel tag beyond NCH on the three-channel instance is dropped
        @(negedge clk);
        bus3.in_valid = 1'b1; bus3.in_ch = 2'd3; bus3.audio_in = 16'h0042;
        @(negedge clk);
        bus3.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
            checkOutput("drop_out_valid", bus3.out_valid, 0);
        end
        @(negedge clk);
        bus3.in_valid = 1'b1; bus3.in_ch = 2'd2; bus3.audio_in = 16'h0042;
        @(negedge clk);
        bus3.in_valid = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("ch2_out_valid", bus3.out_valid, 1);
        checkOutput("ch2_out_ch", bus3.out_ch, 2);
        checkOutput("ch2_audio_out", bus3.audio_out, 16'h0042);

        // Randomized traffic against the history model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = row(0, 1'($urandom_range(0, 1)), 16'($urandom()), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 16'h0, 0, 0);
            v.valid = ($urandom_range(0, 9) < 7);
            v.clr   = ($urandom_range(0, 19) == 0);
            applyStimulus(v, 1'b1);
        end
        idle(4);
        checkOutput("scoreboard_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
